// File: rtl/fft_mag_wr.sv
// FFT output post-processing: alpha-max-beta-min magnitude, one frame of spectrum
// RAM writes, DC-excluded peak tracking and the end-of-run shutdown pulse.
module fft_mag_wr #(
    parameter int FFT_N  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int MAG_W  = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fft_valid,
    input  logic                     fft_out_valid,
    input  logic                     fft_out_last,
    input  logic signed [DATA_W-1:0] fft_re,
    input  logic signed [DATA_W-1:0] fft_im,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_waddr,
    output logic [MAG_W-1:0]         ram_wdata,
    output logic                     fft_shutdown,
    output logic [ADDR_W-1:0]        peak_idx,
    output logic [MAG_W-1:0]         peak_mag,
    output logic                     frame_err,
    output logic                     busy
);

    // state   | meaning
    // IDLE    | waiting for a fresh fft_valid assertion (armed)
    // CAPTURE | accepting beats, bin counter advancing
    // FLUSH   | two cycles for the magnitude pipeline to drain
    // DONE    | one-cycle fft_shutdown pulse
    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_N - 1);
    localparam logic [ADDR_W-1:0] HALF_BIN = ADDR_W'(FFT_N / 2);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] bin_cnt, bin_cnt_nxt;
    logic              armed, armed_nxt;
    logic              flush_cnt, flush_cnt_nxt;
    logic              frame_err_nxt;
    logic              peak_clr;
    logic              beat;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_abs_re, s1_abs_im;
    logic [ADDR_W-1:0] s1_idx;
    logic [DATA_W-1:0] abs_re, abs_im;
    logic [DATA_W-1:0] mag_max, mag_min;
    logic [MAG_W-1:0]  mag;
    logic              in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin_cnt   <= '0;
            armed     <= 1'b1;
            flush_cnt <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bin_cnt   <= bin_cnt_nxt;
            armed     <= armed_nxt;
            flush_cnt <= flush_cnt_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bin_cnt_nxt   = bin_cnt;
        armed_nxt     = armed;
        flush_cnt_nxt = flush_cnt;
        frame_err_nxt = frame_err;
        peak_clr      = 1'b0;
        beat          = 1'b0;
        case (state)
            IDLE: begin
                bin_cnt_nxt = '0;
                if (!fft_valid) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    armed_nxt     = 1'b0;
                    frame_err_nxt = 1'b0;
                    peak_clr      = 1'b1;
                    state_nxt     = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!fft_valid) begin
                    state_nxt   = IDLE;
                    bin_cnt_nxt = '0;
                end else if (fft_out_valid) begin
                    beat = 1'b1;
                    if (bin_cnt == LAST_BIN) begin
                        state_nxt     = FLUSH;
                        bin_cnt_nxt   = '0;
                        flush_cnt_nxt = 1'b0;
                        if (!fft_out_last) frame_err_nxt = 1'b1;
                    end else if (fft_out_last) begin
                        // short frame: restart from bin 0 and forget its peak
                        frame_err_nxt = 1'b1;
                        bin_cnt_nxt   = '0;
                        peak_clr      = 1'b1;
                    end else begin
                        bin_cnt_nxt = bin_cnt + ADDR_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt) begin
                    flush_cnt_nxt = 1'b0;
                    state_nxt     = DONE;
                end else begin
                    flush_cnt_nxt = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fft_shutdown = (state == DONE);
    assign busy         = (state != IDLE);

    // -(-2^(DATA_W-1)) wraps to 2^(DATA_W-1), which is exact as unsigned
    assign abs_re = fft_re[DATA_W-1] ? unsigned'(-fft_re) : unsigned'(fft_re);
    assign abs_im = fft_im[DATA_W-1] ? unsigned'(-fft_im) : unsigned'(fft_im);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_abs_re <= '0;
            s1_abs_im <= '0;
            s1_idx    <= '0;
        end else begin
            s1_valid <= beat;
            if (beat) begin
                s1_abs_re <= abs_re;
                s1_abs_im <= abs_im;
                s1_idx    <= bin_cnt;
            end
        end
    end

    assign mag_max  = (s1_abs_re >= s1_abs_im) ? s1_abs_re : s1_abs_im;
    assign mag_min  = (s1_abs_re >= s1_abs_im) ? s1_abs_im : s1_abs_re;
    assign mag      = {1'b0, mag_max} + MAG_W'(mag_min >> 1);
    assign in_range = (s1_idx != '0) && (s1_idx < HALF_BIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            peak_idx  <= '0;
            peak_mag  <= '0;
        end else begin
            ram_we <= s1_valid;
            if (s1_valid) begin
                ram_waddr <= s1_idx;
                ram_wdata <= mag;
            end
            if (peak_clr) begin
                peak_idx <= '0;
                peak_mag <= '0;
            end else if (s1_valid && in_range && (mag > peak_mag)) begin
                peak_idx <= s1_idx;
                peak_mag <= mag;
            end
        end
    end

endmodule

// File: tb/tb_fft_mag_wr.sv
// Randomised scoreboard bench for fft_mag_wr: stimulus queues expected writes,
// a negedge monitor pops and compares them; peaks come from a frame-level model.
module tb_fft_mag_wr;

    localparam int FFT_N  = 1024;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int MAG_W  = 17;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     fft_valid = 1'b0;
    logic                     fft_out_valid = 1'b0;
    logic                     fft_out_last = 1'b0;
    logic signed [DATA_W-1:0] fft_re = '0;
    logic signed [DATA_W-1:0] fft_im = '0;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_waddr;
    logic [MAG_W-1:0]         ram_wdata;
    logic                     fft_shutdown;
    logic [ADDR_W-1:0]        peak_idx;
    logic [MAG_W-1:0]         peak_mag;
    logic                     frame_err;
    logic                     busy;

    fft_mag_wr #(.FFT_N(FFT_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAG_W(MAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .fft_valid(fft_valid), .fft_out_valid(fft_out_valid),
        .fft_out_last(fft_out_last), .fft_re(fft_re), .fft_im(fft_im), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .fft_shutdown(fft_shutdown),
        .peak_idx(peak_idx), .peak_mag(peak_mag), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data; int cyc;} wr_t;
    wr_t exp_q[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int sd_cnt = 0;
    int sd_cyc = -1;
    int n_wr = 0;
    int re_a[FFT_N];
    int im_a[FFT_N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int mag_of(input int re, input int im);
        int ar, ai, mx, mn;
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        mx = (ar > ai) ? ar : ai;
        mn = (ar > ai) ? ai : ar;
        return mx + mn / 2;
    endfunction

    // largest magnitude among bins 1..FFT_N/2-1 of the first n bins; first occurrence wins
    task automatic ref_peak(input int n, output int pi, output int pm);
        pi = 0;
        pm = 0;
        for (int b = 1; b < n && b < FFT_N / 2; b++) begin
            if (mag_of(re_a[b], im_a[b]) > pm) begin
                pm = mag_of(re_a[b], im_a[b]);
                pi = b;
            end
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (ram_we) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d want no write", ram_waddr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", ram_waddr, e.addr);
                chk("wr_data", ram_wdata, e.data);
                chk("wr_latency_cyc", cyc, e.cyc);
            end
        end
        if (fft_shutdown) begin
            sd_cnt++;
            sd_cyc = cyc;
        end
    end

    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int re, input int im, input bit last, input int bin);
        fft_out_valid = 1'b1;
        fft_out_last  = last;
        fft_re        = 16'(re);
        fft_im        = 16'(im);
        exp_q.push_back('{bin, mag_of(re, im), cyc + 2});
        idle_cyc(1);
        fft_out_valid = 1'b0;
        fft_out_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input int last_at, input int gap_mode, output int c_last);
        c_last = cyc;
        for (int b = 0; b < n; b++) begin
            c_last = cyc;
            beat(re_a[b], im_a[b], b == last_at, b);
            if (gap_mode == 1 && b < n - 1) idle_cyc(1);
            else if (gap_mode == 2 && b < n - 1) idle_cyc(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic start_run();
        fft_valid = 1'b1;
        idle_cyc(1);
    endtask

    task automatic finish_check(input string tag, input int c_last, input int sd0, input int fe);
        int pi, pm;
        idle_cyc(6);
        ref_peak(FFT_N, pi, pm);
        chk({tag, "_shutdowns"}, sd_cnt - sd0, 1);
        chk({tag, "_shutdown_cyc"}, sd_cyc, c_last + 3);
        chk({tag, "_peak_idx"}, peak_idx, pi);
        chk({tag, "_peak_mag"}, peak_mag, pm);
        chk({tag, "_frame_err"}, frame_err, fe);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pending"}, exp_q.size(), 0);
        fft_valid = 1'b0;
        idle_cyc(2);
    endtask

    task automatic load_tone();
        for (int b = 0; b < FFT_N; b++) begin
            re_a[b] = 0;
            im_a[b] = 0;
        end
        re_a[50] = 1000;
        im_a[50] = -400;
    endtask

    task automatic load_rand(input int lim);
        for (int b = 0; b < FFT_N; b++) begin
            re_a[b] = int'($urandom_range(0, 2 * lim)) - lim;
            im_a[b] = int'($urandom_range(0, 2 * lim)) - lim;
        end
    endtask

    initial begin
        int c_last, sd0, wr0, pi, pm, busy_seen;

        idle_cyc(3);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_waddr", ram_waddr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_shutdown", fft_shutdown, 0);
        chk("rst_peak_idx", peak_idx, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle_cyc(2);

        // single tone
        load_tone();
        sd0 = sd_cnt;
        start_run();
        chk("tone_busy_after_start", busy, 1);
        run_frame(FFT_N, FFT_N - 1, 0, c_last);
        finish_check("tone", c_last, sd0, 0);
        chk("tone_model_mag", mag_of(re_a[50], im_a[50]), 1200);

        // ties and excluded bins
        for (int b = 0; b < FFT_N; b++) begin
            re_a[b] = 0;
            im_a[b] = 0;
        end
        re_a[0] = 5000;
        re_a[30] = 300;
        re_a[40] = 300;
        re_a[600] = 4000;
        sd0 = sd_cnt;
        start_run();
        run_frame(FFT_N, FFT_N - 1, 0, c_last);
        finish_check("ties", c_last, sd0, 0);
        chk("ties_peak_is_30", peak_idx, 30);

        // full-scale negative inputs with alternating gaps
        for (int b = 0; b < FFT_N; b++) begin
            re_a[b] = -32768;
            im_a[b] = -32768;
        end
        sd0 = sd_cnt;
        wr0 = n_wr;
        start_run();
        run_frame(FFT_N, FFT_N - 1, 1, c_last);
        finish_check("extreme", c_last, sd0, 0);
        chk("extreme_write_count", n_wr - wr0, FFT_N);
        chk("extreme_peak_mag", peak_mag, 49152);

        // random data, random gaps
        for (int r = 0; r < 2; r++) begin
            load_rand(32767);
            sd0 = sd_cnt;
            start_run();
            run_frame(FFT_N, FFT_N - 1, 2, c_last);
            finish_check("random", c_last, sd0, 0);
        end

        // early last: a stale short frame with a big bin, then a full random frame
        for (int b = 0; b < FFT_N; b++) begin
            re_a[b] = 0;
            im_a[b] = 0;
        end
        re_a[100] = 32000;
        sd0 = sd_cnt;
        start_run();
        run_frame(FFT_N / 2, FFT_N / 2 - 1, 0, c_last);
        chk("early_frame_err_set", frame_err, 1);
        load_rand(10000);
        run_frame(FFT_N, FFT_N - 1, 0, c_last);
        finish_check("early_last", c_last, sd0, 1);

        // missing last on the final bin
        load_rand(20000);
        sd0 = sd_cnt;
        start_run();
        run_frame(FFT_N, -1, 0, c_last);
        finish_check("no_last", c_last, sd0, 1);

        // abort after 300 beats, then fft_valid held high must not restart
        load_rand(32767);
        sd0 = sd_cnt;
        start_run();
        run_frame(300, -1, 0, c_last);
        fft_valid = 1'b0;
        idle_cyc(1);
        fft_valid = 1'b1;
        fft_out_valid = 1'b1;
        fft_re = 16'sd1234;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            idle_cyc(1);
            if (busy) busy_seen = 1;
        end
        fft_out_valid = 1'b0;
        ref_peak(300, pi, pm);
        chk("abort_shutdowns", sd_cnt - sd0, 0);
        chk("abort_busy_while_high", busy_seen, 0);
        chk("abort_peak_idx", peak_idx, pi);
        chk("abort_peak_mag", peak_mag, pm);
        chk("abort_frame_err", frame_err, 0);
        chk("abort_pending", exp_q.size(), 0);
        fft_valid = 1'b0;
        idle_cyc(1);
        sd0 = sd_cnt;
        start_run();
        chk("abort_rearm_busy", busy, 1);
        run_frame(FFT_N, FFT_N - 1, 0, c_last);
        finish_check("after_abort", c_last, sd0, 0);

        // reset in the middle of capture
        load_tone();
        start_run();
        run_frame(700, -1, 0, c_last);
        sd0 = sd_cnt;
        wr0 = n_wr;
        rst_n = 1'b0;
        fft_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_peak_idx", peak_idx, 0);
        chk("midrst_peak_mag", peak_mag, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ram_wdata", ram_wdata, 0);
        idle_cyc(3);
        rst_n = 1'b1;
        idle_cyc(4);
        chk("midrst_no_writes", n_wr - wr0, 0);
        chk("midrst_no_shutdown", sd_cnt - sd0, 0);
        sd0 = sd_cnt;
        start_run();
        run_frame(FFT_N, FFT_N - 1, 0, c_last);
        finish_check("after_reset", c_last, sd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
